// File: rtl/ddr2_controller_dmaster_b2p_if.sv
// Byte-in / packet-out handshake bundle for the debug master bytes-to-packets decoder.
// The decoder uses the slave modport; the driving side (adapter or bench) uses master.
interface ddr2_controller_dmaster_b2p_if #(
  parameter int unsigned CHANNEL_WIDTH = 8
);
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [7:0]               out_data;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic [CHANNEL_WIDTH-1:0] out_channel;
  logic                     out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel
  );
endinterface

// File: rtl/ddr2_controller_dmaster_b2p.sv
// Avalon-ST bytes-to-packets decoder: strips 0x7A-0x7D control characters from the byte
// stream and emits data bytes with SOP/EOP/channel sideband through one register stage.
module ddr2_controller_dmaster_b2p #(
  parameter int unsigned CHANNEL_WIDTH = 8
) (
  input logic                          clk,
  input logic                          reset_n,
  ddr2_controller_dmaster_b2p_if.slave bus
);

  logic                     out_valid_q;
  logic [7:0]               out_data_q;
  logic                     out_sop_q;
  logic                     out_eop_q;
  logic [CHANNEL_WIDTH-1:0] out_channel_q;
  logic                     sop_pend_q;
  logic                     eop_pend_q;
  logic                     esc_pend_q;
  logic                     chan_pend_q;

  logic       in_ready;
  logic       accept;
  logic       is_ctrl;
  logic [7:0] value;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign value    = esc_pend_q ? (bus.in_data ^ 8'h20) : bus.in_data;
  // An escaped byte is never a control character, even if it decodes to one.
  assign is_ctrl  = !esc_pend_q && (bus.in_data inside {[8'h7a:8'h7d]});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= 8'h00;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_channel_q <= '0;
      sop_pend_q    <= 1'b0;
      eop_pend_q    <= 1'b0;
      esc_pend_q    <= 1'b0;
      chan_pend_q   <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        if (is_ctrl) begin
          case (bus.in_data)
            8'h7a: begin
              sop_pend_q  <= 1'b1;
              chan_pend_q <= 1'b0;
            end
            8'h7b: begin
              eop_pend_q  <= 1'b1;
              chan_pend_q <= 1'b0;
            end
            8'h7c:   chan_pend_q <= 1'b1;
            default: esc_pend_q  <= 1'b1;
          endcase
        end else begin
          esc_pend_q <= 1'b0;
          if (chan_pend_q) begin
            out_channel_q <= value[CHANNEL_WIDTH-1:0];
            chan_pend_q   <= 1'b0;
          end else begin
            out_valid_q <= 1'b1;
            out_data_q  <= value;
            out_sop_q   <= sop_pend_q;
            out_eop_q   <= eop_pend_q;
            sop_pend_q  <= 1'b0;
            eop_pend_q  <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.in_ready          = in_ready;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_data          = out_data_q;
  assign bus.out_startofpacket = out_sop_q;
  assign bus.out_endofpacket   = out_eop_q;
  assign bus.out_channel       = out_channel_q;

endmodule

// File: tb/tb_ddr2_controller_dmaster_b2p.sv
// Bench for the bytes-to-packets decoder: directed streams plus randomly encoded packets,
// checked against a packet-level expected queue.
module tb_ddr2_controller_dmaster_b2p;
  localparam int unsigned CW = 8;

  typedef struct {
    logic [7:0] b;
    bit         is_data;
    logic [7:0] val;
  } stim_t;

  typedef struct {
    logic [7:0] d;
    bit         sop;
    bit         eop;
    logic [7:0] ch;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  ddr2_controller_dmaster_b2p_if #(.CHANNEL_WIDTH(CW)) bus ();

  ddr2_controller_dmaster_b2p #(.CHANNEL_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  stim_t      stim_q[$];
  exp_t       exp_q[$];
  logic [7:0] cur_ch = 8'h00;
  bit         lat_pend = 1'b0;
  logic [7:0] lat_data = 8'h00;
  bit         hold_req = 1'b0;
  int         hold_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_raw(input logic [7:0] b, input bit is_data, input logic [7:0] val);
    stim_t s;
    s.b = b;
    s.is_data = is_data;
    s.val = val;
    stim_q.push_back(s);
  endtask

  // Golden encoder: escape any value that collides with a control character.
  task automatic push_enc(input logic [7:0] v, input bit is_data);
    if (v inside {[8'h7a:8'h7d]}) begin
      push_raw(8'h7d, 1'b0, 8'h00);
      push_raw(v ^ 8'h20, is_data, v);
    end else begin
      push_raw(v, is_data, v);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input bit sop, input bit eop);
    exp_t e;
    e.d = d;
    e.sop = sop;
    e.eop = eop;
    e.ch = cur_ch;
    exp_q.push_back(e);
  endtask

  task automatic set_channel(input logic [7:0] ch);
    push_raw(8'h7c, 1'b0, 8'h00);
    push_enc(ch, 1'b0);
    cur_ch = ch & 8'((1 << CW) - 1);
  endtask

  // Drives queued bytes with random gaps and checks every output cycle until drained.
  task automatic run(input int vpct, input int rpct, input int max_cycles);
    int cyc = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0 || lat_pend) && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      if (lat_pend) begin
        check("latency_valid", 32'(bus.out_valid), 32'd1);
        check("latency_data", 32'(bus.out_data), 32'(lat_data));
        lat_pend = 1'b0;
      end
      if (hold_req && bus.out_valid) begin
        hold_cnt = 5;
        hold_req = 1'b0;
      end
      if (hold_cnt > 0) begin
        bus.out_ready = 1'b0;
        hold_cnt--;
      end else begin
        bus.out_ready = ($urandom_range(99) < rpct);
      end
      bus.in_valid = (stim_q.size() > 0) && ($urandom_range(99) < vpct);
      bus.in_data  = (stim_q.size() > 0) ? stim_q[0].b : 8'($urandom);
      #1;
      check("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid) begin
        check("out_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("out_data", 32'(bus.out_data), 32'(exp_q[0].d));
          check("out_sop", 32'(bus.out_startofpacket), 32'(exp_q[0].sop));
          check("out_eop", 32'(bus.out_endofpacket), 32'(exp_q[0].eop));
          check("out_channel", 32'(bus.out_channel), 32'(exp_q[0].ch));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (stim_q[0].is_data) begin
          lat_pend = 1'b1;
          lat_data = stim_q[0].val;
        end
        void'(stim_q.pop_front());
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("drain_left", 32'(stim_q.size() + exp_q.size()), 32'd0);
    stim_q.delete();
    exp_q.delete();
    lat_pend = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_sop"}, 32'(bus.out_startofpacket), 32'd0);
    check({tag, "_eop"}, 32'(bus.out_endofpacket), 32'd0);
    check({tag, "_channel"}, 32'(bus.out_channel), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Sideband decode
    push_raw(8'h7a, 0, 0); push_raw(8'h7c, 0, 0); push_raw(8'h03, 0, 0);
    push_raw(8'h11, 1, 8'h11); push_raw(8'h22, 1, 8'h22);
    push_raw(8'h7b, 0, 0); push_raw(8'h33, 1, 8'h33);
    cur_ch = 8'h03;
    push_exp(8'h11, 1, 0); push_exp(8'h22, 0, 0); push_exp(8'h33, 0, 1);
    run(100, 100, 200);

    // Escapes, including an escaped channel value
    push_raw(8'h7d, 0, 0); push_raw(8'h5a, 1, 8'h7a);
    push_raw(8'h7d, 0, 0); push_raw(8'h5d, 1, 8'h7d);
    push_exp(8'h7a, 0, 0); push_exp(8'h7d, 0, 0);
    push_raw(8'h7c, 0, 0); push_raw(8'h7d, 0, 0); push_raw(8'h5c, 0, 0);
    cur_ch = 8'h7c;
    push_raw(8'h55, 1, 8'h55);
    push_exp(8'h55, 0, 0);
    run(100, 100, 200);

    // Single-byte packet
    push_raw(8'h7a, 0, 0); push_raw(8'h7b, 0, 0); push_raw(8'h44, 1, 8'h44);
    push_exp(8'h44, 1, 1);
    run(100, 100, 200);

    // Backpressure: output held for five cycles
    hold_req = 1'b1;
    push_raw(8'h7a, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) push_raw(8'h7b, 0, 0);
      push_raw(8'(i), 1, 8'(i));
      push_exp(8'(i), i == 1, i == 4);
    end
    run(100, 100, 200);

    // Reset with SOP and escape pending
    push_raw(8'h7a, 0, 0); push_raw(8'h7d, 0, 0);
    run(100, 100, 200);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    cur_ch = 8'h00;
    push_raw(8'h41, 1, 8'h41);
    push_exp(8'h41, 0, 0);
    run(100, 100, 200);

    // Random packets, channels and handshakes
    for (int p = 0; p < 30; p++) begin
      int len;
      if (p == 0 || $urandom_range(2) == 0) set_channel(8'($urandom));
      len = $urandom_range(1, 6);
      if ($urandom_range(3) == 0) push_raw(8'h7a, 0, 0);
      push_raw(8'h7a, 0, 0);
      for (int i = 0; i < len; i++) begin
        logic [7:0] b;
        if (i == len - 1) push_raw(8'h7b, 0, 0);
        b = ($urandom_range(1) == 0) ? 8'(8'h7a + $urandom_range(3)) : 8'($urandom);
        push_enc(b, 1'b1);
        push_exp(b, i == 0, i == len - 1);
      end
    end
    run(70, 60, 20000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
